// File: rtl/i2s_audio_tx.sv
// -----------------------------------------------------------------------------
// i2s_audio_tx
//
// Drift-free I2S transmitter for 16-bit stereo audio. A fractional phase
// accumulator produces a tick train whose long-run rate is exactly
// 2*BCK_HZ ticks per second of clk32. Every tick toggles the bit clock, so
// hp_bck averages BCK_HZ with at most one clk32 cycle of jitter per half
// period. Each 32-slot frame carries left (WS=0) then right (WS=1), MSB
// first, in Philips I2S format: WS leads each channel's MSB by one bit and
// the DAC samples hp_din on the rising edge of hp_bck.
//
// Parameters
//   CLK_HZ      frequency of clk32 in Hz
//   BCK_HZ      target bit-clock frequency; 2*BCK_HZ must be below CLK_HZ
//
// Ports
//   clk32       system clock, single domain
//   por         asynchronous active-high reset
//   audio_l     left sample, two's complement, latched at frame start
//   audio_r     right sample, two's complement, latched at frame start
//   mute        sampled at frame start; high means the frame carries zeros
//   sample_stb  one-cycle pulse when a new L/R pair has been latched
//   hp_bck      I2S bit clock
//   hp_ws       I2S word select (0 = left, 1 = right)
//   hp_din      I2S serial data, MSB first
// -----------------------------------------------------------------------------
module i2s_audio_tx #(
  parameter int CLK_HZ = 32000000,
  parameter int BCK_HZ = 1536000
) (
  input  logic        clk32,
  input  logic        por,
  input  logic [15:0] audio_l,
  input  logic [15:0] audio_r,
  input  logic        mute,
  output logic        sample_stb,
  output logic        hp_bck,
  output logic        hp_ws,
  output logic        hp_din
);

  // Accumulator width: wide enough to hold CLK_HZ + STEP, so acc + STEP
  // never exceeds the W+1 bit comparison range.
  localparam int W = $clog2(CLK_HZ + 2 * BCK_HZ);

  localparam logic [W:0]   STEP    = (W + 1)'(2 * BCK_HZ);
  localparam logic [W:0]   CLK_LIM = (W + 1)'(CLK_HZ);
  localparam logic [W-1:0] CLK_LO  = W'(CLK_HZ);

  // First and last slot (inclusive) during which WS is high. WS rises one
  // slot before the right-channel MSB (slot 16) and falls one slot before
  // the left-channel MSB (slot 0, reached after slot 31).
  localparam logic [4:0] WS_HI_FIRST = 5'd15;
  localparam logic [4:0] WS_HI_LAST  = 5'd30;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [W-1:0] acc;    // fractional phase, always below CLK_HZ
  logic [4:0]   cnt;    // current slot within the frame
  logic [31:0]  frame;  // {left, right} being shifted out

  // ---------------------------------------------------------------------------
  // Phase accumulator
  // ---------------------------------------------------------------------------
  logic [W:0]   acc_sum;
  logic [W-1:0] acc_wrap;
  logic         tick;

  assign acc_sum  = {1'b0, acc} + STEP;
  assign tick     = (acc_sum >= CLK_LIM);
  // The true difference is below STEP, so modulo-2^W subtraction is exact.
  assign acc_wrap = acc_sum[W-1:0] - CLK_LO;

  // ---------------------------------------------------------------------------
  // Next-slot values, used only on a falling tick
  // ---------------------------------------------------------------------------
  logic [4:0]  cnt_next;
  logic        frame_wrap;
  logic [31:0] frame_next;
  logic        din_next;
  logic        ws_next;

  // NOTE: every signal written here gets a value on every path through the
  // block (defaults first); a path that leaves one unassigned infers a latch.
  always_comb begin
    cnt_next   = cnt + 5'd1;
    frame_wrap = (cnt == 5'd31);
    frame_next = frame;
    if (frame_wrap) begin
      frame_next = mute ? 32'd0 : {audio_l, audio_r};
    end
    // Slot 0 transmits the MSB of the frame loaded on this same edge.
    din_next = frame_next[5'd31 - cnt_next];
    ws_next  = (cnt_next >= WS_HI_FIRST) && (cnt_next <= WS_HI_LAST);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values; blocking here would chain updates within
  // the cycle and diverge from the synthesized flops.
  always_ff @(posedge clk32 or posedge por) begin
    if (por) begin
      acc        <= '0;
      hp_bck     <= 1'b0;
      hp_ws      <= 1'b0;
      hp_din     <= 1'b0;
      sample_stb <= 1'b0;
      // Starting at slot 31 makes the first falling tick latch a frame.
      cnt        <= 5'd31;
      // NOTE: the frame register is reset too, so no stale audio from
      // before reset can ever reach hp_din.
      frame      <= '0;
    end else begin
      acc        <= tick ? acc_wrap : acc_sum[W-1:0];
      sample_stb <= 1'b0;

      if (tick) begin
        hp_bck <= ~hp_bck;

        // Falling tick: advance the slot and present the next bit so it is
        // stable for a full half period before the DAC's rising-edge sample.
        if (hp_bck) begin
          cnt        <= cnt_next;
          frame      <= frame_next;
          hp_din     <= din_next;
          hp_ws      <= ws_next;
          sample_stb <= frame_wrap;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// -----------------------------------------------------------------------------
// tb_i2s_audio_tx
//
// Directed, self-checking bench for i2s_audio_tx with default parameters
// (32 MHz clk32, 1.536 MHz BCK). Outputs are sampled on the falling edge of
// clk32, half a cycle away from the active edge. Frames are decoded by
// recording hp_din / hp_ws at each hp_bck rising edge, as the DAC does.
// -----------------------------------------------------------------------------
module tb_i2s_audio_tx;

  logic        clk32 = 1'b0;
  logic        por = 1'b0;
  logic [15:0] audio_l = 16'h0000;
  logic [15:0] audio_r = 16'h0000;
  logic        mute = 1'b0;
  logic        sample_stb;
  logic        hp_bck;
  logic        hp_ws;
  logic        hp_din;

  int tests_run = 0;
  int tests_failed = 0;

  // WS word as recorded by capture_frame (bit 31 = slot 0): high in slots
  // 15..30, i.e. bit positions 16..1.
  localparam logic [31:0] WS_EXP = 32'h0001_FFFE;

  i2s_audio_tx dut (
    .clk32      (clk32),
    .por        (por),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .mute       (mute),
    .sample_stb (sample_stb),
    .hp_bck     (hp_bck),
    .hp_ws      (hp_ws),
    .hp_din     (hp_din)
  );

  always #5 clk32 = ~clk32;

  // Safety net in case some bounded loop is mis-sized.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (no comparisons inside)
  // ---------------------------------------------------------------------------
  task automatic apply_action(input int act);
    case (act)
      1: audio_l = 16'h0001;
      2: mute = 1'b1;
      3: mute = 1'b0;
      default: ;
    endcase
  endtask

  task automatic wait_stb(input int budget, output bit found);
    int i;
    found = 1'b0;
    i = 0;
    while (!found && i < budget) begin
      @(negedge clk32);
      i++;
      if (sample_stb) found = 1'b1;
    end
  endtask

  // Waits for the next frame start, then records the 32 slots of that frame.
  // The action 'act' is applied right after slot 'act_slot' is sampled.
  task automatic capture_frame(input int act_slot, input int act,
                               output logic [31:0] data,
                               output logic [31:0] ws, output bit ok);
    bit   found;
    int   slot;
    int   cyc;
    logic prev;
    data = '0;
    ws   = '0;
    ok   = 1'b0;
    wait_stb(800, found);
    if (!found) return;
    prev = hp_bck;
    slot = 0;
    cyc  = 0;
    while (slot < 32 && cyc < 800) begin
      @(negedge clk32);
      cyc++;
      if (hp_bck && !prev) begin
        data[31-slot] = hp_din;
        ws[31-slot]   = hp_ws;
        if (slot == act_slot) apply_action(act);
        slot++;
      end
      prev = hp_bck;
    end
    ok = (slot == 32);
  endtask

  // Releases por (called between clock edges) and checks the first-frame
  // timing: rise after edge 11, fall + strobe after edge 21.
  task automatic check_reset_timing(input string tag);
    int early_hi;
    early_hi = 0;
    por = 1'b0;
    for (int k = 1; k <= 22; k++) begin
      @(negedge clk32);
      if (k <= 10 && hp_bck) early_hi++;
      if (k == 10) begin
        tests_run++;
        if (early_hi !== 0) begin
          tests_failed++;
          $display("FAIL %s_no_early_bck: high in %0d cycles, expected 0", tag, early_hi);
        end
      end
      if (k == 11) begin
        tests_run++;
        if (hp_bck !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s_bck_rise_edge11: got %b expected 1", tag, hp_bck);
        end
      end
      if (k == 20) begin
        tests_run++;
        if (hp_bck !== 1'b1 || sample_stb !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s_edge20: bck=%b stb=%b expected bck=1 stb=0", tag, hp_bck, sample_stb);
        end
      end
      if (k == 21) begin
        tests_run++;
        if (hp_bck !== 1'b0 || sample_stb !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s_fall_edge21: bck=%b stb=%b expected bck=0 stb=1", tag, hp_bck, sample_stb);
        end
        tests_run++;
        if (hp_din !== audio_l[15] || hp_ws !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s_first_bit: din=%b ws=%b expected din=%b ws=0", tag, hp_din, hp_ws, audio_l[15]);
        end
      end
      if (k == 22) begin
        tests_run++;
        if (sample_stb !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s_stb_width: got %b expected 0 one cycle later", tag, sample_stb);
        end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    int bad;
    bad = 0;
    audio_l = 16'hA5C3;
    audio_r = 16'h3C5A;
    mute = 1'b0;
    por = 1'b1;
    repeat (5) begin
      @(negedge clk32);
      if ({sample_stb, hp_bck, hp_ws, hp_din} !== 4'b0000) bad++;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL reset_outputs_low: %0d cycles with nonzero outputs, expected 0", bad);
    end
    check_reset_timing("reset");
  endtask

  task automatic test_bit_pattern();
    logic [31:0] data;
    logic [31:0] ws;
    bit          ok;
    for (int f = 0; f < 2; f++) begin
      capture_frame(-1, 0, data, ws, ok);
      tests_run++;
      if (!ok) begin
        tests_failed++;
        $display("FAIL pattern_frame%0d_timeout: frame not captured, expected 32 slots", f);
      end
      tests_run++;
      if (data !== 32'hA5C3_3C5A) begin
        tests_failed++;
        $display("FAIL pattern_frame%0d_data: got %h expected a5c33c5a", f, data);
      end
      tests_run++;
      if (ws !== WS_EXP) begin
        tests_failed++;
        $display("FAIL pattern_frame%0d_ws: got %h expected %h", f, ws, WS_EXP);
      end
    end
  endtask

  // 32000 cycles = 3072 ticks exactly: 1536 rises, 1536 falls, and strobes
  // on falls 1, 33, ..., 1505 -> 48 frames.
  task automatic test_rate();
    int   rises;
    int   stbs;
    int   bad_frame;
    int   bad_half;
    int   last_stb;
    int   last_edge;
    int   edges;
    logic prev;
    rises = 0; stbs = 0; bad_frame = 0; bad_half = 0;
    last_stb = -1; last_edge = -1; edges = 0;
    por = 1'b1;
    @(negedge clk32);
    por = 1'b0;
    prev = 1'b0;
    for (int c = 1; c <= 32000; c++) begin
      @(negedge clk32);
      if (hp_bck !== prev) begin
        edges++;
        if (hp_bck) rises++;
        if (last_edge >= 0 && (c - last_edge < 10 || c - last_edge > 11)) bad_half++;
        last_edge = c;
      end
      if (sample_stb) begin
        stbs++;
        if (last_stb >= 0 && (c - last_stb < 666 || c - last_stb > 667)) bad_frame++;
        last_stb = c;
      end
      prev = hp_bck;
    end
    tests_run++;
    if (rises !== 1536) begin
      tests_failed++;
      $display("FAIL rate_bck_rises: got %0d expected 1536", rises);
    end
    tests_run++;
    if (stbs !== 48) begin
      tests_failed++;
      $display("FAIL rate_stb_count: got %0d expected 48", stbs);
    end
    tests_run++;
    if (bad_frame !== 0) begin
      tests_failed++;
      $display("FAIL rate_frame_interval: %0d intervals outside 666..667, expected 0", bad_frame);
    end
    tests_run++;
    if (bad_half !== 0 || edges !== 3072) begin
      tests_failed++;
      $display("FAIL rate_half_period: %0d bad of %0d edges, expected 0 bad of 3072", bad_half, edges);
    end
  endtask

  task automatic test_mid_frame_change();
    logic [31:0] data;
    logic [31:0] ws;
    bit          ok;
    capture_frame(5, 1, data, ws, ok);
    tests_run++;
    if (!ok || data !== 32'hA5C3_3C5A) begin
      tests_failed++;
      $display("FAIL midchange_current: got %h ok=%b expected a5c33c5a", data, ok);
    end
    capture_frame(-1, 0, data, ws, ok);
    tests_run++;
    if (!ok || data !== 32'h0001_3C5A) begin
      tests_failed++;
      $display("FAIL midchange_next: got %h ok=%b expected 00013c5a", data, ok);
    end
  endtask

  task automatic test_mute();
    logic [31:0] data;
    logic [31:0] ws;
    bit          ok;
    // Changed before the next frame boundary, so the next frame carries it.
    audio_l = 16'hA5C3;
    capture_frame(20, 2, data, ws, ok);
    tests_run++;
    if (!ok || data !== 32'hA5C3_3C5A) begin
      tests_failed++;
      $display("FAIL mute_current_unchanged: got %h ok=%b expected a5c33c5a", data, ok);
    end
    capture_frame(10, 3, data, ws, ok);
    tests_run++;
    if (!ok || data !== 32'h0000_0000) begin
      tests_failed++;
      $display("FAIL mute_zero_frame: got %h ok=%b expected 00000000", data, ok);
    end
    tests_run++;
    if (ws !== WS_EXP) begin
      tests_failed++;
      $display("FAIL mute_ws_kept: got %h expected %h", ws, WS_EXP);
    end
    capture_frame(-1, 0, data, ws, ok);
    tests_run++;
    if (!ok || data !== 32'hA5C3_3C5A) begin
      tests_failed++;
      $display("FAIL mute_released: got %h ok=%b expected a5c33c5a", data, ok);
    end
  endtask

  task automatic test_reset_mid_frame();
    bit   found;
    int   slot;
    int   cyc;
    logic prev;
    wait_stb(800, found);
    prev = hp_bck;
    slot = 0;
    cyc = 0;
    // Stop at the rising edge of slot 10 (cnt = 10, hp_bck = 1).
    while (found && slot < 11 && cyc < 800) begin
      @(negedge clk32);
      cyc++;
      if (hp_bck && !prev) slot++;
      prev = hp_bck;
    end
    tests_run++;
    if (!found || slot !== 11 || hp_bck !== 1'b1) begin
      tests_failed++;
      $display("FAIL midreset_setup: found=%b slot=%0d bck=%b expected slot 11 with bck=1", found, slot, hp_bck);
    end
    #1 por = 1'b1;
    #1;
    tests_run++;
    if ({sample_stb, hp_bck, hp_ws, hp_din} !== 4'b0000) begin
      tests_failed++;
      $display("FAIL midreset_async: stb/bck/ws/din=%b expected 0000 before any clock edge",
               {sample_stb, hp_bck, hp_ws, hp_din});
    end
    repeat (3) @(posedge clk32);
    @(negedge clk32);
    check_reset_timing("midreset");
  endtask

  initial begin
    test_reset();
    test_bit_pattern();
    test_rate();
    test_mid_frame_change();
    test_mute();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
